// File: rtl/ram_arbiter.sv
// Round-robin arbiter: instruction fetch (p0, read-only) and load/store (p1) sharing one
// single-port read-first RAM. Define RAM_ARB_RMW_EN for byte-strobed read-modify-write.
module ram_arbiter #(
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = DATA_WIDTH/8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_p0_req,
  input  logic [AW-1:0]         i_p0_addr,
  output logic                  o_p0_gnt,
  output logic                  o_p0_rvalid,
  output logic [DATA_WIDTH-1:0] o_p0_rdata,
  input  logic                  i_p1_req,
  input  logic                  i_p1_we,
  input  logic [AW-1:0]         i_p1_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  input  logic [BW-1:0]         i_p1_be,
  output logic                  o_p1_gnt,
  output logic                  o_p1_rvalid,
  output logic [DATA_WIDTH-1:0] o_p1_rdata,
  output logic [AW-1:0]         o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  logic last_q, last_d;
  logic p0Rvalid_q, p0Rvalid_d;
  logic p1Rvalid_q, p1Rvalid_d;
  logic gnt0, gnt1;
  logic inMerge;
  logic fullBe;

`ifdef RAM_ARB_RMW_EN
  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         mAddr_q, mAddr_d;
  logic [DATA_WIDTH-1:0] mWdata_q, mWdata_d;
  logic [BW-1:0]         mBe_q, mBe_d;
  logic                  partialBe;
  logic [DATA_WIDTH-1:0] mergedData;

  assign inMerge   = (state_q == MERGE);
  assign fullBe    = &i_p1_be;
  assign partialBe = (|i_p1_be) && !(&i_p1_be);

  // The RAM is read-first, so during MERGE i_ram_data holds the word read on the grant cycle.
  always_comb begin
    mergedData = '0;
    for (int b = 0; b < BW; b++) begin
      mergedData[8*b +: 8] = mBe_q[b] ? mWdata_q[8*b +: 8] : i_ram_data[8*b +: 8];
    end
  end
`else
  assign inMerge = 1'b0;
  assign fullBe  = |i_p1_be;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_rst_n && !inMerge) begin
      gnt0 = i_p0_req && (!i_p1_req || last_q);
      gnt1 = i_p1_req && (!i_p0_req || !last_q);
    end
  end

  assign o_p0_gnt = gnt0;
  assign o_p1_gnt = gnt1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q     <= 1'b1;
      p0Rvalid_q <= 1'b0;
      p1Rvalid_q <= 1'b0;
`ifdef RAM_ARB_RMW_EN
      state_q    <= IDLE;
      mAddr_q    <= '0;
      mWdata_q   <= '0;
      mBe_q      <= '0;
`endif
    end else begin
      last_q     <= last_d;
      p0Rvalid_q <= p0Rvalid_d;
      p1Rvalid_q <= p1Rvalid_d;
`ifdef RAM_ARB_RMW_EN
      state_q    <= state_d;
      mAddr_q    <= mAddr_d;
      mWdata_q   <= mWdata_d;
      mBe_q      <= mBe_d;
`endif
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt1) begin
      last_d = 1'b1;
    end else if (gnt0) begin
      last_d = 1'b0;
    end
    p0Rvalid_d = gnt0;
    p1Rvalid_d = gnt1 && !i_p1_we;
`ifdef RAM_ARB_RMW_EN
    state_d  = state_q;
    mAddr_d  = mAddr_q;
    mWdata_d = mWdata_q;
    mBe_d    = mBe_q;
    case (state_q)
      IDLE: begin
        if (gnt1 && i_p1_we && partialBe) begin
          state_d  = MERGE;
          mAddr_d  = i_p1_addr;
          mWdata_d = i_p1_wdata;
          mBe_d    = i_p1_be;
        end
      end
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
`endif
  end

  // A granted partial write leaves o_ram_we low so the grant cycle reads the old word.
  always_comb begin
    o_ram_addr = '0;
    o_ram_data = '0;
    o_ram_we   = 1'b0;
`ifdef RAM_ARB_RMW_EN
    if (inMerge) begin
      o_ram_addr = mAddr_q;
      o_ram_data = mergedData;
      o_ram_we   = 1'b1;
    end else
`endif
    if (gnt0) begin
      o_ram_addr = i_p0_addr;
    end else if (gnt1) begin
      o_ram_addr = i_p1_addr;
      if (i_p1_we && fullBe) begin
        o_ram_data = i_p1_wdata;
        o_ram_we   = 1'b1;
      end
    end
  end

  assign o_p0_rvalid = p0Rvalid_q;
  assign o_p1_rvalid = p1Rvalid_q;
  assign o_p0_rdata  = p0Rvalid_q ? i_ram_data : '0;
  assign o_p1_rdata  = p1Rvalid_q ? i_ram_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural read-first RAM attached.
// Exercises the RAM_ARB_RMW_EN merge path when that macro is defined, else the full-write path.
module tb_ram_arbiter;

  localparam int DEPTH = 256;
  localparam int DW    = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = DW/8;

  logic          clk;
  logic          rstN;
  logic          p0Req;
  logic [AW-1:0] p0Addr;
  logic          p0Gnt, p0Rvalid;
  logic [DW-1:0] p0Rdata;
  logic          p1Req, p1We;
  logic [AW-1:0] p1Addr;
  logic [DW-1:0] p1Wdata;
  logic [BW-1:0] p1Be;
  logic          p1Gnt, p1Rvalid;
  logic [DW-1:0] p1Rdata;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramWdata;
  logic          ramWe;
  logic [DW-1:0] ramRdata;

  logic [DW-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_p0_req    (p0Req),
    .i_p0_addr   (p0Addr),
    .o_p0_gnt    (p0Gnt),
    .o_p0_rvalid (p0Rvalid),
    .o_p0_rdata  (p0Rdata),
    .i_p1_req    (p1Req),
    .i_p1_we     (p1We),
    .i_p1_addr   (p1Addr),
    .i_p1_wdata  (p1Wdata),
    .i_p1_be     (p1Be),
    .o_p1_gnt    (p1Gnt),
    .o_p1_rvalid (p1Rvalid),
    .o_p1_rdata  (p1Rdata),
    .o_ram_addr  (ramAddr),
    .o_ram_data  (ramWdata),
    .o_ram_we    (ramWe),
    .i_ram_data  (ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port read-first synchronous RAM, as seen by the arbiter
  always @(posedge clk) begin
    ramRdata <= mem[ramAddr];
    if (ramWe) mem[ramAddr] <= ramWdata;
  end

  // Compares one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives a new input vector just after the next rising edge
  task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0,
                               input logic r1, input logic we1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] wd1, input logic [BW-1:0] be1);
    @(posedge clk);
    #1;
    p0Req = r0;  p0Addr = a0;
    p1Req = r1;  p1We = we1;  p1Addr = a1;  p1Wdata = wd1;  p1Be = be1;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rstN = 1'b0;
    p0Req = 1'b0; p1Req = 1'b0; p1We = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'hAABBCCDD;
    ramRdata = '0;
    rstN = 1'b0;
    p0Req = 1'b1; p0Addr = 8'h10;
    p1Req = 1'b1; p1We = 1'b1; p1Addr = 8'h20; p1Wdata = 32'hFFFFFFFF; p1Be = 4'hF;

    // Reset values, with both requests high to show grants are held off
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_p0_gnt",    32'(p0Gnt),    32'd0);
    checkOutput("rst_p1_gnt",    32'(p1Gnt),    32'd0);
    checkOutput("rst_p0_rvalid", 32'(p0Rvalid), 32'd0);
    checkOutput("rst_p1_rvalid", 32'(p1Rvalid), 32'd0);
    checkOutput("rst_p0_rdata",  p0Rdata,       32'd0);
    checkOutput("rst_p1_rdata",  p1Rdata,       32'd0);
    checkOutput("rst_ram_we",    32'(ramWe),    32'd0);
    checkOutput("rst_ram_addr",  32'(ramAddr),  32'd0);
    checkOutput("rst_ram_data",  ramWdata,      32'd0);
    p0Req = 1'b0; p1Req = 1'b0; p1We = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Single p0 read of 0x10
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_p0_gnt",  32'(p0Gnt),   32'd1);
    checkOutput("rd_ram_addr", 32'(ramAddr), 32'h10);
    checkOutput("rd_ram_we",  32'(ramWe),   32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_p0_rvalid", 32'(p0Rvalid), 32'd1);
    checkOutput("rd_p0_rdata",  p0Rdata,       32'hDEADBEEF);
    checkOutput("rd_p1_rvalid", 32'(p1Rvalid), 32'd0);
    checkOutput("rd_p0_gnt_off", 32'(p0Gnt),   32'd0);

    // Continuous contention from reset: p0, p1, p0, p1
    applyReset();
    applyStimulus(1, 8'h10, 1, 0, 8'h30, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d_p0_gnt", i), 32'(p0Gnt), 32'((i % 2) == 0));
      checkOutput($sformatf("rr%0d_p1_gnt", i), 32'(p1Gnt), 32'((i % 2) == 1));
      checkOutput($sformatf("rr%0d_p0_rvalid", i), 32'(p0Rvalid), 32'((i % 2) == 1));
      checkOutput($sformatf("rr%0d_p1_rvalid", i), 32'(p1Rvalid), 32'(i == 2));
      checkOutput($sformatf("rr%0d_p0_rdata", i), p0Rdata, ((i % 2) == 1) ? 32'hDEADBEEF : 32'h0);
      checkOutput($sformatf("rr%0d_p1_rdata", i), p1Rdata, (i == 2) ? 32'hAABBCCDD : 32'h0);
      @(posedge clk);
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0);

    // Full write then read-back the following cycle
    applyStimulus(0, 8'h00, 1, 1, 8'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    checkOutput("wr_p1_gnt",   32'(p1Gnt),   32'd1);
    checkOutput("wr_ram_we",   32'(ramWe),   32'd1);
    checkOutput("wr_ram_addr", 32'(ramAddr), 32'h20);
    checkOutput("wr_ram_data", ramWdata,     32'h12345678);
    applyStimulus(0, 8'h00, 1, 0, 8'h20, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("wr_no_rvalid", 32'(p1Rvalid), 32'd0);
    checkOutput("rb_ram_we",    32'(ramWe),    32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rb_p1_rvalid", 32'(p1Rvalid), 32'd1);
    checkOutput("rb_p1_rdata",  p1Rdata,       32'h12345678);

    // Write with be=0 is granted but touches nothing
    applyStimulus(0, 8'h00, 1, 1, 8'h40, 32'hCAFEF00D, 4'h0);
    @(negedge clk);
    checkOutput("be0_p1_gnt", 32'(p1Gnt), 32'd1);
    checkOutput("be0_ram_we", 32'(ramWe), 32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("be0_no_rvalid", 32'(p1Rvalid), 32'd0);
    checkOutput("be0_mem", mem[8'h40], 32'h0);

    // Partial write while p0 also requests; a p0 read first moves last to 0 so p1 wins
    applyReset();
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, 8'h10, 1, 1, 8'h30, 32'h11223344, 4'b0101);
    @(negedge clk);
    checkOutput("pw_p1_gnt", 32'(p1Gnt), 32'd1);
    checkOutput("pw_p0_gnt", 32'(p0Gnt), 32'd0);
`ifdef RAM_ARB_RMW_EN
    checkOutput("pw_rd_we",   32'(ramWe),   32'd0);
    checkOutput("pw_rd_addr", 32'(ramAddr), 32'h30);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("mg_p0_gnt",    32'(p0Gnt),    32'd0);
    checkOutput("mg_p1_gnt",    32'(p1Gnt),    32'd0);
    checkOutput("mg_ram_we",    32'(ramWe),    32'd1);
    checkOutput("mg_ram_addr",  32'(ramAddr),  32'h30);
    checkOutput("mg_ram_data",  ramWdata,      32'hAA22CC44);
    checkOutput("mg_p1_rvalid", 32'(p1Rvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mg_after_p0_gnt", 32'(p0Gnt), 32'd1);
    applyStimulus(0, 8'h00, 1, 0, 8'h30, 32'h0, 4'h0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("mg_rb_rdata", p1Rdata, 32'hAA22CC44);

    // Reset in the middle of a merge abandons the write
    applyStimulus(0, 8'h00, 1, 1, 8'h30, 32'h55667788, 4'b0101);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    p1Req = 1'b0; p1We = 1'b0;
    @(negedge clk);
    checkOutput("mrst_ram_we",   32'(ramWe),   32'd0);
    checkOutput("mrst_ram_addr", 32'(ramAddr), 32'h0);
    checkOutput("mrst_ram_data", ramWdata,     32'h0);
    checkOutput("mrst_p1_gnt",   32'(p1Gnt),   32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("mrst_mem", mem[8'h30], 32'hAA22CC44);
`else
    checkOutput("fw_ram_we",   32'(ramWe),   32'd1);
    checkOutput("fw_ram_data", ramWdata,     32'h11223344);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("fw_next_p0_gnt", 32'(p0Gnt), 32'd1);
    applyStimulus(0, 8'h00, 1, 0, 8'h30, 32'h0, 4'h0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("fw_rb_rdata", p1Rdata, 32'h11223344);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
